// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the Cardinal NIC: processor register map and packet VC bit position.
package cardinal_nic_pkg;

  localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

  // Packets use [0:63] ordering, so the VC bit is the MSB at index 0.
  localparam int VC_BIT = 0;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet register with a full flag; writes only land while empty.
module nic_channel_buffer #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [0:DATA_WIDTH-1] wr_data,
  input  logic                  clr,
  output logic [0:DATA_WIDTH-1] data,
  output logic                  full
);

  // A clear only acts on a full entry, and a write only acts on an empty one,
  // so a write arriving while full (or in the same cycle as a clear) is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (full) begin
      if (clr) full <= 1'b0;
    end else if (wr_en) begin
      data <= wr_data;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC: bridges NIC-mapped processor loads/stores to one ring router port.
module cardinal_nic
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  output logic                  net_si,
  input  logic                  net_ri,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity,
  input  logic                  net_so,
  output logic                  net_ro,
  input  logic [0:DATA_WIDTH-1] net_di
);

  logic                  load_en;
  logic                  store_en;
  logic                  in_clr;
  logic                  out_wr;
  logic                  in_full;
  logic                  out_full;
  logic [0:DATA_WIDTH-1] in_buf;
  logic [0:DATA_WIDTH-1] out_buf;

  assign load_en  = nicEn & ~nicWrEn;
  assign store_en = nicEn & nicWrEn;
  assign in_clr   = load_en & (addr == NIC_ADDR_IN_BUF);
  assign out_wr   = store_en & (addr == NIC_ADDR_OUT_BUF);

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_in_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (net_so),
    .wr_data (net_di),
    .clr     (in_clr),
    .data    (in_buf),
    .full    (in_full)
  );

  nic_channel_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_out_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (out_wr),
    .wr_data (d_in),
    .clr     (net_si),
    .data    (out_buf),
    .full    (out_full)
  );

  // Injection waits until the router's VC polarity matches the packet's VC bit.
  assign net_si = out_full & net_ri & (out_buf[VC_BIT] == net_polarity);
  assign net_do = out_buf;
  assign net_ro = ~in_full;

  always_comb begin
    d_out = '0;
    if (load_en) begin
      case (addr)
        NIC_ADDR_IN_BUF:   d_out = in_buf;
        NIC_ADDR_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
        NIC_ADDR_OUT_BUF:  d_out = out_buf;
        NIC_ADDR_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:           d_out = '0;
      endcase
    end
  end

endmodule

// File: doc/cardinal_nic.md
Name: cardinal_nic

Overview:
- Network interface controller that sits between the Cardinal processor's NIC-mapped memory port and one local port of the ring router.
- Responder for processor loads and stores to the NIC address window. The processor selects a register with a 2-bit address.
- Provides one 64-bit input channel buffer (router to processor) and one 64-bit output channel buffer (processor to router).
- Each buffer has a full flag exposed through a status register.
- Router side uses a send/ready handshake, gated by the router's VC polarity on injection.

Parameters:
- DATA_WIDTH, 64, width of packets, registers and processor data.
- ADDR_WIDTH, 2, width of the processor register address.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- addr  input  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- d_in  input  64  store data from processor (din_nic).
- d_out  output  64  load data to processor (dout_nic), combinational from addr and state.
- nicEn  input  1  access enable.
- nicWrEn  input  1  1 = store, 0 = load; ignored when nicEn=0.
- net_si  output  1  send to router; single-cycle pulse.
- net_ri  input  1  router ready to accept a packet from the NIC.
- net_do  output  64  packet to router.
- net_polarity  input  1  router's current VC polarity.
- net_so  input  1  router sending a packet to the NIC.
- net_ro  output  1  NIC ready to accept a packet from the router.
- net_di  input  64  packet from router.

Behaviour:
- Bit order is [0:63]: bit 0 is MSB and is the packet VC bit; bit 63 is LSB.
- Reset (reset=0 at clk edge):
  - in_buf=0, in_full=0, out_buf=0, out_full=0.
  - Resulting outputs: net_si=0, net_ro=1, net_do=0.
  - d_out follows the combinational rule below, so with nicEn=0 it is 0.
  - Reset wins over any same-cycle access or handshake; an in-flight packet is discarded.
- Processor loads (nicEn=1, nicWrEn=0), data valid in the same cycle:
  - addr 00: d_out=in_buf. If in_full=1, in_full clears at the edge.
  - addr 01: d_out={63'b0,in_full}.
  - addr 10: d_out=out_buf. No state change.
  - addr 11: d_out={63'b0,out_full}.
  - When nicEn=0 or nicWrEn=1: d_out=0.
- Processor stores (nicEn=1, nicWrEn=1):
  - addr 10 with out_full=0: out_buf<=d_in and out_full<=1.
  - addr 10 with out_full=1: store dropped, no state change.
  - Stores to 00, 01, 11 are ignored.
- Router to NIC:
  - net_ro = ~in_full (combinational).
  - On net_so=1 and in_full=0: in_buf<=net_di and in_full<=1.
  - net_so=1 with in_full=1 is a protocol violation; the packet is dropped and the buffer is unchanged.
- NIC to router:
  - net_do=out_buf.
  - net_si = out_full & net_ri & (out_buf[0]==net_polarity) (combinational).
  - In a cycle with net_si=1, out_full clears at the edge. Transfer latency is 1 cycle.
- Simultaneous events:
  - Load of addr 00 and net_so in the same cycle: cannot occur legally, since net_ro=0 while full.
  - After a load clears in_full, net_ro rises in the next cycle, and a new packet may land in the cycle after that.
  - Store to addr 10 in the same cycle as a send: the store is dropped because out_full=1 at the edge; software must poll status.
- No FIFO depth beyond one entry per direction. No wrap-around.

Decomposition:
- Shared package cardinal_nic_pkg:
  - Address constants NIC_ADDR_IN_BUF=2'b00, NIC_ADDR_IN_STAT=2'b01, NIC_ADDR_OUT_BUF=2'b10, NIC_ADDR_OUT_STAT=2'b11.
  - Constant VC_BIT=0.
- Sub-module nic_channel_buffer:
  - One-entry 64-bit register with full flag, write-when-empty and clear ports.
  - Instantiated twice, once for input and once for output.
- The top module holds the address decode, the d_out mux and the handshake gating.

Test Plan:
- Reset: hold reset=0 for 2 cycles -> net_ro=1, net_si=0, net_do=0; loads of addr 01 and 11 return 64'h0.
- Receive: net_so=1 with net_di=64'hA5A5_0000_0000_0001 -> next cycle net_ro=0 and addr 01 reads 64'h1. Load addr 00 returns the packet; the cycle after, net_ro=1 and status 01 reads 0.
- Send with polarity:
  - Store 64'h8000_0000_0000_0042 to addr 10, net_ri=1, net_polarity=0 -> net_si stays 0.
  - Flip net_polarity=1 -> net_si=1 for exactly one cycle with net_do=64'h8000_0000_0000_0042; then addr 11 reads 0.
- Back-pressure: out_full=1, net_ri=0 for 5 cycles, store 64'h1234 to addr 10 -> net_si=0 throughout and out_buf keeps its original value (store dropped).
- Overflow drop: in_full=1, then assert net_so=1 with net_di=64'hFFFF -> in_buf unchanged, net_ro stays 0.
- Reset mid-operation: both buffers full, assert reset=0 during net_si=1 -> next cycle both status registers read 0, net_si=0, net_ro=1.
